// File: rtl/button_debouncer_pkg.sv
// Shared types and constants for the 4-button front end.
// The encoder and decoder reuse the one-hot constants below.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CANDIDATE = 2'd1,
        HELD      = 2'd2,
        RELEASE   = 2'd3
    } state_e;

    localparam logic [3:0] ONEHOT_RESET = 4'b1000;

    localparam logic [3:0] BTN0 = 4'b1000;
    localparam logic [3:0] BTN1 = 4'b0100;
    localparam logic [3:0] BTN2 = 4'b0010;
    localparam logic [3:0] BTN3 = 4'b0001;

endpackage

// File: rtl/button_debouncer_if.sv
// Button front-end bundle: raw buttons in, clean one-hot code out.
// The slave modport is the debouncer side.
interface button_debouncer_if;

    logic [3:0] buttons;
    logic [3:0] out;
    logic       valid;
    logic       busy;

    modport master (
        output buttons,
        input  out,
        input  valid,
        input  busy
    );

    modport slave (
        input  buttons,
        output out,
        output valid,
        output busy
    );

endinterface

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Both stages clear to zero on reset.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces four buttons and emits a registered one-hot code plus a
// one-cycle valid strobe for each accepted single-button press.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input logic               clk,
    input logic               reset_n,
    button_debouncer_if.slave btn
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       out_q, out_d;
    logic             valid_q, valid_d;
    logic [3:0]       s;

    function automatic logic onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    sync_2ff #(
        .W (4)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (btn.buttons),
        .q_o     (s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        out_d   = out_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (onehot4(s)) begin
                    cand_d  = s;
                    cnt_d   = CNT_ONE;
                    state_d = CANDIDATE;
                end
            end
            CANDIDATE: begin
                if (s != cand_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    out_d   = cand_q;
                    valid_d = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                // Any non-zero pattern keeps us here until a full release.
                if (s == 4'b0000) begin
                    cnt_d   = CNT_ONE;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (s != 4'b0000) begin
                    cnt_d   = '0;
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            out_q   <= ONEHOT_RESET;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign btn.out   = out_q;
    assign btn.valid = valid_q;
    assign btn.busy  = (state_q != IDLE);

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Front-end conditioning stage for the 4-button application circuit. It sits directly upstream of the 4-to-2 encoder and feeds it.
- Synchronises four raw, bouncy, active-high button lines and debounces them.
- Drives a clean, registered one-hot code for the encoder, plus a one-cycle valid strobe per accepted press.
- Only single-button presses are accepted. Multi-button or zero patterns never reach the encoder, so its input is always exactly one-hot.

Parameters:
- DEBOUNCE_CYCLES, 4: number of consecutive equal synchronised samples needed to accept a press or a release. Legal range 2..255.
- CNT_W, 8: width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- buttons  input  4  raw asynchronous button levels, active-high; bit 3 = button 0 (pattern 1000), bit 0 = button 3 (pattern 0001).
- out  output  4  last accepted one-hot code, registered; feeds the encoder input.
- valid  output  1  one-cycle pulse in the cycle where out takes a newly accepted code.
- busy  output  1  high while not in IDLE.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately with no clock edge needed):
  - out = 4'b1000, so the encoder shows 00.
  - valid = 0, busy = 0.
  - Synchroniser flops = 0, counter = 0, candidate = 0, state = IDLE.
- Release of reset is sampled on the next clk edge. Reset asserted mid-debounce aborts the operation; there are no partial updates.
- Synchroniser: two flops on buttons. Sample s = second flop output. The FSM uses only s.
- onehot(s): true when exactly one bit of s is set. Valid patterns are 1000, 0100, 0010, 0001.
- FSM states and transitions:
  - IDLE:
    - onehot(s) → candidate = s, cnt = 1, go to CANDIDATE.
    - Otherwise (0000 or multi-bit) → stay in IDLE.
  - CANDIDATE:
    - s == candidate and cnt == DEBOUNCE_CYCLES-1 → out = candidate, valid = 1 for one cycle, go to HELD.
    - s == candidate, count not reached → cnt++.
    - s != candidate (bounce, other button, extra button) → go to IDLE, cnt = 0, out unchanged, no valid.
  - HELD:
    - s == 0000 → cnt = 1, go to RELEASE.
    - Otherwise → stay. Extra buttons or a changed button while held are ignored; no new code is accepted until a full release.
  - RELEASE:
    - s == 0000 and cnt == DEBOUNCE_CYCLES-1 → go to IDLE.
    - s == 0000, count not reached → cnt++.
    - s != 0000 → go to HELD, cnt = 0.
- out holds its value across all states. It changes only on acceptance, and re-pressing the same button re-accepts it (valid pulses again).
- valid is registered and high for exactly one cycle per accepted press; it is never high in two consecutive cycles.
- Latency: raw one-hot applied before edge 0 and held stable → out and valid update at edge DEBOUNCE_CYCLES+1 (edge 5 for the default value).
- Counter: saturation is never reached because cnt is bounded by DEBOUNCE_CYCLES-1. Width rule per CNT_W.
- busy = (state != IDLE), combinational from the state register.

Decomposition:
- Shared package / include:
  - FSM state encodings (IDLE=2'd0, CANDIDATE=2'd1, HELD=2'd2, RELEASE=2'd3).
  - Reset code constant ONEHOT_RESET = 4'b1000.
  - The four legal one-hot constants. The encoder and decoder reuse these.
- One natural sub-module: sync_2ff, a parameterised-width two-flop synchroniser with asynchronous active-low reset to 0, instantiated with width 4.
- The onehot check is a local function, not a module.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset check: assert reset_n=0 mid-cycle with buttons=0100 → out=1000, valid=0, busy=0 immediately, with no clk edge needed.
- Clean press: buttons=0010 stable from edge 0 → out=0010 and valid=1 after edge 5 only. valid=0 after edge 6. Encoder downstream reads 10.
- Bounce: buttons toggles 0001/0000 every cycle for 10 cycles, then holds 0001 → no valid during the bounce. Exactly one valid, out=0001, at the 5th edge after stable hold begins.
- Multi-button: buttons=0110 for 20 cycles → busy=0, out unchanged (1000), valid never asserted.
- Hold then swap: accept 1000, then change to 0100 without releasing → no valid. Release to 0000 for ≥4 synchronised cycles, then 0100 → valid once, out=0100.
- Release glitch: after accepting 0100, go to 0000 for 2 cycles, 0100 for 1 cycle, then 0000 → FSM returns to HELD with no valid. IDLE is reached only after 4 consecutive zero samples. Pressing 0100 again then yields valid=1 and out=0100.
